button_debounce: RTL and testbench

- Conditions the raw push-button input for the dice block, which rolls while its `button` input is high.
- Synchronises the asynchronous pad signal and rejects contact bounce with a stability counter.
- Emits a clean level for the dice, plus one-cycle press/release pulses and a long-press flag for later stages (display hold, mode select).
- Sits directly between the board button pin and the dice `button` input.

---
 rtl/dice_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 29 ++
 rtl/button_debounce.sv | 137 +++++++++++++
 tb/tb_button_debounce.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dice_pkg.sv
// Shared definitions for the dice project.
// Holds the push-button conditioner's state encoding and its default
// timing constants, so the dice top and the board top agree on them.
package dice_pkg;

  // Conditioner FSM states.
  //   RELEASED     - button accepted as up
  //   PRESS_WAIT   - input went high, waiting for it to stay high long enough
  //   PRESSED      - button accepted as down
  //   RELEASE_WAIT - input went low, waiting for it to stay low long enough
  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

  // Simulation-friendly defaults.
  // Board builds override DEBOUNCE_CYCLES to 1_000_000, which is 10 ms at 100 MHz.
  localparam int DEBOUNCE_CYCLES_DEF   = 16;
  localparam int LONG_PRESS_CYCLES_DEF = 64;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
// It is reused by every pad-input block.
// Ports:
//   clk - destination clock
//   rst - synchronous, active-high reset; clears both flops
//   d   - asynchronous input
//   q   - synchronised output, two clock edges behind d
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  // The first flop may go metastable.
  // The second flop gives it a full clock period to settle before anyone uses q.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner for the dice block.
// It synchronises the raw pad signal and rejects contact bounce with a
// stability counter. It produces a clean level plus one-cycle press/release
// strobes and a long-press flag.
// Ports:
//   clk           - system clock
//   rst           - synchronous, active-high reset
//   button_raw    - asynchronous, bouncy pad input (1 = pressed)
//   button_db     - debounced level; drives the dice 'button' input
//   press_pulse   - one-cycle strobe when a press is accepted
//   release_pulse - one-cycle strobe when a release is accepted
//   long_press    - high once the button has been held LONG_PRESS_CYCLES
//                   cycles in PRESSED; cleared on the accepted release
module button_debounce
  import dice_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF,
  parameter int CNT_W             = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic button_raw,
  output logic button_db,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_MAX  = CNT_W'(LONG_PRESS_CYCLES);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);

  logic             s2;
  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             db_d, pp_d, rp_d, lp_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (button_raw),
    .q   (s2)
  );

  // State, counters and all outputs are registered here.
  // Nothing combinational reaches the output ports from button_raw.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RELEASED;
      cnt_q         <= '0;
      hold_q        <= '0;
      button_db     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      button_db     <= db_d;
      press_pulse   <= pp_d;
      release_pulse <= rp_d;
      long_press    <= lp_d;
    end
  end

  // Next-state and next-output logic.
  // Level outputs hold their value by default and the strobes default to 0.
  // cnt restarts on every WAIT entry, so it never needs to wrap.
  // hold_cnt advances only while settled in PRESSED and saturates at
  // LONG_PRESS_CYCLES. A bounce through RELEASE_WAIT freezes hold_cnt
  // rather than clearing it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    db_d    = button_db;
    pp_d    = 1'b0;
    rp_d    = 1'b0;
    lp_d    = long_press;

    unique case (state_q)
      RELEASED: begin
        if (s2) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end

      PRESS_WAIT: begin
        if (!s2) begin
          state_d = RELEASED;
        end else if (cnt_q == DB_LAST) begin
          state_d = PRESSED;
          db_d    = 1'b1;
          pp_d    = 1'b1;
          hold_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      PRESSED: begin
        if (!s2) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else if (hold_q != LP_MAX) begin
          hold_d = hold_q + 1'b1;
          if (hold_q == LP_LAST) begin
            lp_d = 1'b1;
          end
        end
      end

      RELEASE_WAIT: begin
        if (s2) begin
          state_d = PRESSED;
        end else if (cnt_q == DB_LAST) begin
          state_d = RELEASED;
          db_d    = 1'b0;
          lp_d    = 1'b0;
          rp_d    = 1'b1;
          hold_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = RELEASED;
      end
    endcase
  end

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce.
// Stimulus applies raw/reset values one cycle at a time. For each cycle it
// advances a run-length reference model and queues the output vector that
// must appear after that clock edge. A separate monitor compares DUT
// outputs against the queue one time unit after every rising edge.
module tb_button_debounce;

  localparam int D = 16;
  localparam int L = 64;

  logic clk;
  logic rst;
  logic button_raw;
  logic button_db;
  logic press_pulse;
  logic release_pulse;
  logic long_press;

  typedef struct {
    int         cyc;
    logic [3:0] v;
  } exp_item_t;

  exp_item_t sb[$];

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  // Reference model state.
  // pipe1/pipe2 model the two-cycle synchroniser delay.
  // run counts consecutive observed samples that disagree with the accepted level.
  // held counts settled high samples since the press was accepted.
  logic m_pipe1, m_pipe2, m_db, m_long, m_pp, m_rp;
  int   m_run, m_held;

  button_debounce #(
    .DEBOUNCE_CYCLES   (D),
    .LONG_PRESS_CYCLES (L),
    .CNT_W             (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .button_raw    (button_raw),
    .button_db     (button_db),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_press    (long_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the reference model by one clock edge.
  // A level change is accepted once the observed input has disagreed with
  // the accepted level for D+1 consecutive edges. The first of those edges
  // enters the wait state; the next D confirm the new level.
  task automatic modelStep(input logic raw, input logic r);
    logic seen;
    if (r) begin
      m_pipe1 = 1'b0; m_pipe2 = 1'b0;
      m_db = 1'b0; m_long = 1'b0; m_pp = 1'b0; m_rp = 1'b0;
      m_run = 0; m_held = 0;
    end else begin
      seen    = m_pipe2;
      m_pipe2 = m_pipe1;
      m_pipe1 = raw;
      m_pp    = 1'b0;
      m_rp    = 1'b0;
      if (seen != m_db) begin
        m_run++;
        if (m_run == D + 1) begin
          m_run  = 0;
          m_held = 0;
          if (!m_db) begin
            m_db = 1'b1;
            m_pp = 1'b1;
          end else begin
            m_db   = 1'b0;
            m_rp   = 1'b1;
            m_long = 1'b0;
          end
        end
      end else begin
        // Counting only happens while settled high, not on the edge that returns from a bounce.
        if (m_db && m_run == 0 && m_held < L) begin
          m_held++;
          if (m_held == L) m_long = 1'b1;
        end
        m_run = 0;
      end
    end
  endtask

  // Drive raw/reset for n cycles and queue the expected outputs for each edge.
  task automatic applyStimulus(input logic raw, input logic r, input int n);
    exp_item_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      button_raw = raw;
      rst        = r;
      modelStep(raw, r);
      cyc++;
      e.cyc = cyc;
      e.v   = {m_db, m_pp, m_rp, m_long};
      sb.push_back(e);
    end
  endtask

  task automatic checkOutput(input exp_item_t e);
    logic [3:0] act;
    act = {button_db, press_pulse, release_pulse, long_press};
    compared++;
    if (act !== e.v) begin
      mismatched++;
      $display("[TB] FAIL outputs cycle %0d: got db/pp/rp/lp=%b required %b", e.cyc, act, e.v);
    end
    compared++;
    if (press_pulse === 1'b1 && release_pulse === 1'b1) begin
      mismatched++;
      $display("[TB] FAIL pulse_overlap cycle %0d: got pp=1 rp=1 required not both", e.cyc);
    end
  endtask

  // Monitor: sample just after each active edge and compare against the oldest expectation.
  always @(posedge clk) begin
    exp_item_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput(e);
    end
  end

  initial begin
    logic lvl;
    int   len;
    button_raw = 1'b0;
    rst        = 1'b1;
    m_pipe1 = 1'b0; m_pipe2 = 1'b0; m_db = 1'b0; m_long = 1'b0;
    m_pp = 1'b0; m_rp = 1'b0; m_run = 0; m_held = 0;

    $display("[TB] reset");
    applyStimulus(1'b0, 1'b1, 3);
    applyStimulus(1'b0, 1'b0, 5);

    $display("[TB] clean press");
    applyStimulus(1'b1, 1'b0, 40);
    applyStimulus(1'b0, 1'b0, 30);

    $display("[TB] bounce rejection");
    applyStimulus(1'b1, 1'b0, 10);
    applyStimulus(1'b0, 1'b0, 3);
    applyStimulus(1'b1, 1'b0, 10);
    applyStimulus(1'b0, 1'b0, 30);

    $display("[TB] press then bouncy release");
    applyStimulus(1'b1, 1'b0, 30);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 2);
      applyStimulus(1'b1, 1'b0, 2);
    end
    applyStimulus(1'b0, 1'b0, 30);

    $display("[TB] long press");
    applyStimulus(1'b1, 1'b0, 120);
    applyStimulus(1'b0, 1'b0, 30);

    $display("[TB] reset mid press-wait");
    applyStimulus(1'b1, 1'b0, 10);
    applyStimulus(1'b1, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 40);
    applyStimulus(1'b0, 1'b0, 30);

    $display("[TB] glitch while pressed");
    applyStimulus(1'b1, 1'b0, 30);
    applyStimulus(1'b0, 1'b0, 5);
    applyStimulus(1'b1, 1'b0, 100);
    applyStimulus(1'b0, 1'b0, 30);

    $display("[TB] random bursts");
    lvl = 1'b0;
    for (int b = 0; b < 80; b++) begin
      lvl = ~lvl;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: len = $urandom_range(1, 6);
        4, 5, 6:    len = $urandom_range(14, 22);
        7, 8:       len = $urandom_range(23, 90);
        default:    len = 0;
      endcase
      if (len == 0) begin
        applyStimulus(lvl, 1'b1, 1);
      end else begin
        applyStimulus(lvl, 1'b0, len);
      end
    end
    applyStimulus(1'b0, 1'b0, 30);

    repeat (2) @(posedge clk);
    #2;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
